// File: rtl/cipher_word_decoder.sv
// cipher_word_decoder
//   Undoes the co-processor's two-pass bit-permutation cipher on 16-bit words.
//   A word is accepted on a valid/ready input. It is run through ROUNDS inverse
//   rounds, where each round is pass A (P2inv) followed by pass B (P1inv), one
//   cycle per pass. The plaintext is then presented on a valid/ready output.
//   Only one word is in flight at a time.
//
// Parameters
//   ROUNDS      inverse rounds per word, 1..15
// Ports
//   clk         clock, rising edge
//   reset       synchronous, active-high
//   in_valid    ciphertext present on in_data
//   in_ready    decoder idle and able to accept a word
//   in_data     ciphertext word
//   out_valid   plaintext present on out_data
//   out_ready   consumer takes out_data
//   out_data    plaintext word (meaningful only while out_valid)
//   busy        high whenever the decoder is not idle
//   word_count  words delivered since reset, modulo 256
module cipher_word_decoder #(
    parameter int ROUNDS = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        busy,
    output logic [7:0]  word_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UNA  = 2'd1,
        UNB  = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t      state;
    logic [15:0] work;
    logic [3:0]  rnd;

    // Inverse of the second forward pass: re-interleaves the two byte halves.
    function automatic logic [15:0] p2inv(input logic [15:0] y);
        return {y[0], y[8],  y[1], y[9],  y[2], y[10], y[3], y[11],
                y[4], y[12], y[5], y[13], y[6], y[14], y[7], y[15]};
    endfunction

    // Inverse of the first forward pass.
    function automatic logic [15:0] p1inv(input logic [15:0] y);
        return {y[15], y[11], y[7],  y[4], y[8], y[14], y[10], y[6],
                y[3],  y[0],  y[13], y[9], y[5], y[2],  y[1],  y[12]};
    endfunction

    // The handshake and status outputs are flops updated together with the
    // state, so they never depend combinationally on any input.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            work       <= 16'h0000;
            rnd        <= 4'd0;
            word_count <= 8'd0;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        work     <= in_data;
                        rnd      <= 4'(ROUNDS - 1);
                        state    <= UNA;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                UNA: begin
                    work  <= p2inv(work);
                    state <= UNB;
                end
                UNB: begin
                    work <= p1inv(work);
                    if (rnd == 4'd0) begin
                        state     <= HOLD;
                        out_valid <= 1'b1;
                    end else begin
                        rnd   <= rnd - 4'd1;
                        state <= UNA;
                    end
                end
                HOLD: begin
                    // The word is held until it is taken. A new word can only
                    // be accepted from IDLE on the following cycle.
                    if (out_ready) begin
                        word_count <= word_count + 8'd1;
                        state      <= IDLE;
                        out_valid  <= 1'b0;
                        busy       <= 1'b0;
                        in_ready   <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    assign out_data = work;

endmodule

// File: tb/tb_cipher_word_decoder.sv
// Testbench for cipher_word_decoder: one instance with ROUNDS=1 (sel 0) and
// one with ROUNDS=2 (sel 1), checked against a table-driven permutation model.
module tb_cipher_word_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
    logic [15:0] a_in_data, a_out_data;
    logic [7:0]  a_word_count;
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
    logic [15:0] b_in_data, b_out_data;
    logic [7:0]  b_word_count;

    int tests = 0;
    int fails = 0;
    int cnt [2];

    // Source bit for output bits 15..0 of each inverse pass.
    int pa_list [16] = '{0, 8, 1, 9, 2, 10, 3, 11, 4, 12, 5, 13, 6, 14, 7, 15};
    int pb_list [16] = '{15, 11, 7, 4, 8, 14, 10, 6, 3, 0, 13, 9, 5, 2, 1, 12};

    typedef struct {
        logic [15:0] din;
        logic [15:0] dout;
    } vec_t;
    vec_t vecs [4];

    always #5 clk = ~clk;

    cipher_word_decoder #(.ROUNDS(1)) dut_a (
        .clk(clk), .reset(reset),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .busy(a_busy), .word_count(a_word_count)
    );

    cipher_word_decoder #(.ROUNDS(2)) dut_b (
        .clk(clk), .reset(reset),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .busy(b_busy), .word_count(b_word_count)
    );

    function automatic logic [15:0] model(input logic [15:0] c, input int rounds);
        logic [15:0] y, t;
        y = c;
        for (int r = 0; r < rounds; r++) begin
            for (int i = 0; i < 16; i++) t[15 - i] = y[pa_list[i]];
            y = t;
            for (int i = 0; i < 16; i++) t[15 - i] = y[pb_list[i]];
            y = t;
        end
        return y;
    endfunction

    function automatic logic rdy(input bit sel);
        return sel ? b_in_ready : a_in_ready;
    endfunction
    function automatic logic ovld(input bit sel);
        return sel ? b_out_valid : a_out_valid;
    endfunction
    function automatic logic [15:0] odata(input bit sel);
        return sel ? b_out_data : a_out_data;
    endfunction
    function automatic logic [7:0] wcnt(input bit sel);
        return sel ? b_word_count : a_word_count;
    endfunction

    task automatic set_in(input bit sel, input logic v, input logic [15:0] d);
        if (sel) begin b_in_valid = v; b_in_data = d; end
        else     begin a_in_valid = v; a_in_data = d; end
    endtask
    task automatic set_ordy(input bit sel, input logic r);
        if (sel) b_out_ready = r; else a_out_ready = r;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One complete word: accept, wait for out_valid (bounded), check, consume.
    task automatic xfer(input bit sel, input logic [15:0] d, input logic [15:0] exp,
                        input int rounds, input string tag);
        int lat;
        check({tag, " in_ready"}, 32'(rdy(sel)), 32'd1);
        set_in(sel, 1'b1, d);
        step();
        set_in(sel, 1'b0, 16'($urandom));
        lat = 0;
        while (!ovld(sel) && lat < 100) begin
            step();
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(2 * rounds));
        check({tag, " data"}, 32'(odata(sel)), 32'(exp));
        set_ordy(sel, 1'b1);
        step();
        set_ordy(sel, 1'b0);
        cnt[sel] = (cnt[sel] + 1) % 256;
        check({tag, " word_count"}, 32'(wcnt(sel)), 32'(cnt[sel]));
    endtask

    initial begin
        logic [15:0] d;
        reset = 1'b1;
        set_in(0, 1'b0, 16'h0); set_in(1, 1'b0, 16'h0);
        set_ordy(0, 1'b0); set_ordy(1, 1'b0);
        cnt[0] = 0; cnt[1] = 0;
        vecs[0] = '{16'h0200, 16'h0001};
        vecs[1] = '{16'h0001, 16'h8000};
        vecs[2] = '{16'hFFFF, 16'hFFFF};
        vecs[3] = '{16'h0000, 16'h0000};

        // Reset for two cycles.
        step(); step();
        reset = 1'b0;
        check("rst in_ready", 32'(a_in_ready), 32'd1);
        check("rst out_valid", 32'(a_out_valid), 32'd0);
        check("rst busy", 32'(a_busy), 32'd0);
        check("rst out_data", 32'(a_out_data), 32'h0);
        check("rst word_count", 32'(a_word_count), 32'd0);
        check("rst b in_ready", 32'(b_in_ready), 32'd1);

        // Directed vectors, ROUNDS=1.
        for (int i = 0; i < 4; i++)
            xfer(0, vecs[i].din, vecs[i].dout, 1, $sformatf("vec%0d", i));

        // ROUNDS=2.
        xfer(1, 16'h0200, 16'h8000, 2, "r2 0x0200");

        // Backpressure: hold the word in HOLD while pulsing a competing input.
        set_in(0, 1'b1, 16'h0200);
        step();
        set_in(0, 1'b0, 16'h0);
        step(); step();
        check("bp out_valid", 32'(a_out_valid), 32'd1);
        for (int i = 0; i < 10; i++) begin
            set_in(0, i[0], 16'h1234);
            step();
            check("bp out_valid hold", 32'(a_out_valid), 32'd1);
            check("bp out_data hold", 32'(a_out_data), 32'h0001);
            check("bp in_ready hold", 32'(a_in_ready), 32'd0);
        end
        set_in(0, 1'b0, 16'h0);
        a_out_ready = 1'b1;
        step();
        a_out_ready = 1'b0;
        cnt[0] = (cnt[0] + 1) % 256;
        check("bp word_count", 32'(a_word_count), 32'(cnt[0]));
        check("bp idle in_ready", 32'(a_in_ready), 32'd1);
        check("bp idle out_valid", 32'(a_out_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("bp 0x1234 not consumed", 32'(a_busy), 32'd0);
        end

        // Reset during UNB with in_valid high.
        set_in(0, 1'b1, 16'hABCD);
        step();               // accepted, now UNA
        step();               // now UNB
        reset = 1'b1;
        step();
        check("mid rst in_ready", 32'(a_in_ready), 32'd1);
        check("mid rst busy", 32'(a_busy), 32'd0);
        check("mid rst out_valid", 32'(a_out_valid), 32'd0);
        check("mid rst word_count", 32'(a_word_count), 32'd0);
        check("mid rst out_data", 32'(a_out_data), 32'h0);
        set_in(0, 1'b0, 16'h0);
        reset = 1'b0;
        cnt[0] = 0; cnt[1] = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("mid rst no out_valid", 32'(a_out_valid), 32'd0);
        end

        // Random words on the ROUNDS=2 instance.
        for (int i = 0; i < 20; i++) begin
            d = 16'($urandom);
            xfer(1, d, model(d, 2), 2, $sformatf("r2 rand%0d", i));
        end

        // Counter wrap: 257 back-to-back random words after a fresh reset.
        reset = 1'b1;
        step();
        reset = 1'b0;
        cnt[0] = 0; cnt[1] = 0;
        for (int i = 0; i < 257; i++) begin
            d = 16'($urandom);
            xfer(0, d, model(d, 1), 1, $sformatf("wrap%0d", i));
        end
        check("wrap final word_count", 32'(a_word_count), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
